// File: rtl/axis_chan_join_n.sv
// N-lane AXI4-Stream joiner: per-lane FIFOs absorb channel skew, and all lanes pop in
// lockstep into one packed output beat, with tlast/tuser agreement checking across lanes.
module axis_chan_join_n #(
  parameter int C                = 3,
  parameter int LW               = 16,
  parameter int UW               = 3,
  parameter int DEPTH            = 4,
  parameter int DROP_ON_MISMATCH = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [C*LW-1:0] s_axis_tdata,
  input  logic [C-1:0]    s_axis_tvalid,
  output logic [C-1:0]    s_axis_tready,
  input  logic [C-1:0]    s_axis_tlast,
  input  logic [C*UW-1:0] s_axis_tuser,
  output logic [C*LW-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic [UW-1:0]   m_axis_tuser,
  output logic            err_pulse,
  output logic            err_sticky,
  output logic [15:0]     err_count,
  output logic [C-1:0]    lane_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = UW + 1 + LW;

  logic            rst_done;
  logic [C-1:0]    full;
  logic [C-1:0]    nonempty;
  logic [C-1:0]    push;
  logic [C-1:0]    head_last;
  logic [LW-1:0]   head_data [C];
  logic [UW-1:0]   head_user [C];
  logic            join_fire;
  logic            mismatch;
  logic            drop;
  logic [C*LW-1:0] join_data;

  // Holds every lane's ready low until the first clock after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  assign join_fire = (&nonempty) && (!m_axis_tvalid || m_axis_tready) && !flush;
  assign lane_full = full;

  for (genvar g = 0; g < C; g++) begin : g_lane
    logic [AW:0]   cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] mem [DEPTH];

    assign full[g]          = (cnt == (AW+1)'(DEPTH));
    assign nonempty[g]      = (cnt != '0);
    assign s_axis_tready[g] = rst_done && !full[g] && !flush;
    assign push[g]          = s_axis_tvalid[g] && s_axis_tready[g];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (flush) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[g])   wr_ptr <= wr_ptr + 1'b1;
        if (join_fire) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + (AW+1)'(push[g]) - (AW+1)'(join_fire);
      end
    end

    // NOTE: storage has no reset; the count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
      if (push[g])
        mem[wr_ptr] <= {s_axis_tuser[g*UW +: UW], s_axis_tlast[g], s_axis_tdata[g*LW +: LW]};
    end

    assign {head_user[g], head_last[g], head_data[g]} = mem[rd_ptr];
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    mismatch  = 1'b0;
    join_data = '0;
    for (int i = 0; i < C; i++) begin
      join_data[i*LW +: LW] = head_data[i];
      if (head_last[i] != head_last[0] || head_user[i] != head_user[0]) mismatch = 1'b1;
    end
  end

  assign drop = (DROP_ON_MISMATCH != 0) && mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      err_pulse     <= 1'b0;
      err_sticky    <= 1'b0;
      err_count     <= '0;
    end else if (flush) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      err_pulse     <= 1'b0;
      err_sticky    <= 1'b0;
      err_count     <= '0;
    end else begin
      // A dropped join still frees the output slot if the held beat was taken this cycle.
      if (join_fire && !drop) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= join_data;
        m_axis_tlast  <= head_last[0];
        m_axis_tuser  <= head_user[0];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      err_pulse <= join_fire && mismatch;
      if (join_fire && mismatch) begin
        err_sticky <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_chan_join_n.sv
// Directed bench for axis_chan_join_n: latency, skew, backpressure, mismatch policies,
// flush and asynchronous reset, with hand-computed expected beats.
module tb_axis_chan_join_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [47:0] s_tdata = '0;
  logic [2:0]  s_tvalid = '0;
  logic [2:0]  s_tready;
  logic [2:0]  s_tlast = '0;
  logic [8:0]  s_tuser = '0;
  logic [47:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [2:0]  m_tuser;
  logic        err_pulse;
  logic        err_sticky;
  logic [15:0] err_count;
  logic [2:0]  lane_full;

  logic        d_flush = 1'b0;
  logic [47:0] d_tdata = '0;
  logic [2:0]  d_tvalid = '0;
  logic [2:0]  d_tready;
  logic [2:0]  d_tlast = '0;
  logic [8:0]  d_tuser = '0;
  logic [47:0] d_m_tdata;
  logic        d_m_tvalid;
  logic        d_m_tready = 1'b1;
  logic        d_m_tlast;
  logic [2:0]  d_m_tuser;
  logic        d_err_pulse;
  logic        d_err_sticky;
  logic [15:0] d_err_count;
  logic [2:0]  d_lane_full;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] got[$];
  logic [63:0] d_got[$];

  always #5 clk = ~clk;

  axis_chan_join_n #(.C(3), .LW(16), .UW(3), .DEPTH(4), .DROP_ON_MISMATCH(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .lane_full(lane_full)
  );

  axis_chan_join_n #(.C(3), .LW(16), .UW(3), .DEPTH(4), .DROP_ON_MISMATCH(1)) u_drop (
    .clk(clk), .rst_n(rst_n), .flush(d_flush),
    .s_axis_tdata(d_tdata), .s_axis_tvalid(d_tvalid), .s_axis_tready(d_tready),
    .s_axis_tlast(d_tlast), .s_axis_tuser(d_tuser),
    .m_axis_tdata(d_m_tdata), .m_axis_tvalid(d_m_tvalid), .m_axis_tready(d_m_tready),
    .m_axis_tlast(d_m_tlast), .m_axis_tuser(d_m_tuser),
    .err_pulse(d_err_pulse), .err_sticky(d_err_sticky), .err_count(d_err_count),
    .lane_full(d_lane_full)
  );

  // Record every completed output handshake as {tlast, tuser, tdata}.
  always @(negedge clk) begin
    if (m_tvalid && m_tready)     got.push_back(64'({m_tlast, m_tuser, m_tdata}));
    if (d_m_tvalid && d_m_tready) d_got.push_back(64'({d_m_tlast, d_m_tuser, d_m_tdata}));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat(input logic last, input logic [2:0] user,
                                       input logic [15:0] d2, input logic [15:0] d1,
                                       input logic [15:0] d0);
    return 64'({last, user, d2, d1, d0});
  endfunction

  function automatic logic [15:0] lane_word(input int l, input int s);
    return 16'(16'h1000 * (l + 1) + s);
  endfunction

  logic [2:0] rdy;
  int         seq;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_lane_full", 64'(lane_full), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(s_tready), 64'h7);

    // Drop policy: beat 2 has lane 1 tuser disagreeing with lane 0
    for (int b = 1; b <= 3; b++) begin
      for (int l = 0; l < 3; l++) d_tdata[l*16 +: 16] = 16'(16'h0B00 + 16 * l + b);
      d_tuser  = (b == 2) ? 9'b000_001_000 : 9'b0;
      d_tvalid = 3'b111;
      tick();
    end
    d_tvalid = '0;
    d_tuser  = '0;
    repeat (5) tick();
    check("drop_count", 64'(d_got.size()), 64'd2);
    check("drop_beat1", (d_got.size() > 0) ? d_got[0] : '1, beat(0, 0, 16'h0B21, 16'h0B11, 16'h0B01));
    check("drop_beat3", (d_got.size() > 1) ? d_got[1] : '1, beat(0, 0, 16'h0B23, 16'h0B13, 16'h0B03));
    check("drop_err_count", 64'(d_err_count), 64'd1);

    // Latency: one beat on all lanes appears two cycles later
    got.delete();
    m_tready = 1'b1;
    s_tdata  = {16'h0033, 16'h0022, 16'h0011};
    s_tvalid = 3'b111;
    tick();
    s_tvalid = '0;
    check("lat_not_yet", 64'(m_tvalid), 64'd0);
    tick();
    check("lat_valid", 64'(m_tvalid), 64'd1);
    check("lat_tdata", 64'(m_tdata), 64'h0033_0022_0011);
    check("lat_err_count", 64'(err_count), 64'd0);
    tick();

    // Skew: lane 0 runs four beats ahead
    got.delete();
    for (int k = 1; k <= 4; k++) begin
      s_tdata  = {16'h0, 16'h0, 16'(k)};
      s_tvalid = 3'b001;
      tick();
    end
    s_tvalid = '0;
    check("skew_full", 64'(lane_full), 64'h1);
    check("skew_ready", 64'(s_tready), 64'h6);
    check("skew_no_out", 64'(m_tvalid), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      s_tdata  = {16'(16'h20 + k), 16'(16'h10 + k), 16'h0};
      s_tvalid = 3'b110;
      tick();
    end
    s_tvalid = '0;
    repeat (4) tick();
    check("skew_count", 64'(got.size()), 64'd4);
    for (int k = 1; k <= 4; k++)
      check($sformatf("skew_beat%0d", k), (k <= got.size()) ? got[k-1] : '1,
            beat(0, 0, 16'(16'h20 + k), 16'(16'h10 + k), 16'(k)));
    check("skew_full_clear", 64'(lane_full), 64'h0);

    // Backpressure: continuous stream with downstream stalled for 10 cycles
    got.delete();
    m_tready = 1'b0;
    seq = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int l = 0; l < 3; l++) s_tdata[l*16 +: 16] = lane_word(l, seq);
      s_tvalid = 3'b111;
      rdy = s_tready;
      if (cyc == 5) check("bp_hold_mid", 64'(m_tdata), 64'({lane_word(2, 0), lane_word(1, 0), lane_word(0, 0)}));
      tick();
      if (rdy == 3'b111) seq++;
    end
    check("bp_accepted", 64'(seq), 64'd5);
    check("bp_ready_low", 64'(s_tready), 64'h0);
    check("bp_valid", 64'(m_tvalid), 64'd1);
    check("bp_hold_end", 64'(m_tdata), 64'({lane_word(2, 0), lane_word(1, 0), lane_word(0, 0)}));
    s_tvalid = '0;
    m_tready = 1'b1;
    repeat (8) tick();
    check("bp_count", 64'(got.size()), 64'd5);
    for (int s = 0; s < 5; s++)
      check($sformatf("bp_beat%0d", s), (s < got.size()) ? got[s] : '1,
            beat(0, 0, lane_word(2, s), lane_word(1, s), lane_word(0, s)));

    // Mismatch with emit policy: lane 2 tlast disagrees
    got.delete();
    s_tdata  = {16'h0A03, 16'h0A02, 16'h0A01};
    s_tuser  = {3'd5, 3'd5, 3'd5};
    s_tlast  = 3'b100;
    s_tvalid = 3'b111;
    tick();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    check("mm_pulse_early", 64'(err_pulse), 64'd0);
    tick();
    check("mm_valid", 64'(m_tvalid), 64'd1);
    check("mm_tlast", 64'(m_tlast), 64'd0);
    check("mm_tuser", 64'(m_tuser), 64'd5);
    check("mm_pulse", 64'(err_pulse), 64'd1);
    check("mm_sticky", 64'(err_sticky), 64'd1);
    check("mm_count", 64'(err_count), 64'd1);
    tick();
    check("mm_pulse_gone", 64'(err_pulse), 64'd0);
    check("mm_sticky_hold", 64'(err_sticky), 64'd1);

    // Flush with two beats buffered and the output held
    m_tready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < 3; l++) s_tdata[l*16 +: 16] = lane_word(l, 16'h40 + b);
      s_tvalid = 3'b111;
      tick();
    end
    s_tvalid = '0;
    check("fl_pre_valid", 64'(m_tvalid), 64'd1);
    flush = 1'b1;
    #1;
    check("fl_ready_low", 64'(s_tready), 64'h0);
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(m_tvalid), 64'd0);
    check("fl_sticky", 64'(err_sticky), 64'd0);
    check("fl_count", 64'(err_count), 64'd0);
    m_tready = 1'b1;
    repeat (2) tick();
    check("fl_empty", 64'(m_tvalid), 64'd0);

    // Asynchronous reset mid-stream
    m_tready = 1'b0;
    s_tdata  = {16'h0C03, 16'h0C02, 16'h0C01};
    s_tvalid = 3'b111;
    tick();
    s_tvalid = '0;
    tick();
    check("ar_pre_valid", 64'(m_tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(m_tvalid), 64'd0);
    check("ar_tdata", 64'(m_tdata), 64'd0);
    check("ar_full", 64'(lane_full), 64'd0);
    tick();
    rst_n = 1'b1;
    m_tready = 1'b1;
    tick();
    check("ar_ready", 64'(s_tready), 64'h7);
    tick();
    check("ar_no_out", 64'(m_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_chan_join_n.md
Name: axis_chan_join_n

Overview:
- Parametrised N-lane stream aligner/joiner for the depthwise→pointwise boundary of the conv pipeline.
- Each of C independent per-channel AXI4-Stream lanes (one per depthwise conv output) is buffered in its own FIFO.
- A beat is popped from all lanes in lockstep only when every lane holds data, and the lanes are emitted as one packed AXI4-Stream beat.
- Per-lane skew between channel pipelines is absorbed, and tlast/tuser disagreement across lanes is detected and handled per a configurable policy.

Parameters:
- C, 3, number of channel lanes (≥1).
- LW, 16, data width per lane in bits.
- UW, 3, tuser width per lane in bits.
- DEPTH, 4, per-lane FIFO depth in entries (power of 2, ≥2).
- DROP_ON_MISMATCH, 0, 0 = emit mismatched beat with lane-0 sideband; 1 = discard mismatched beat.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all FIFOs and the output register.
- s_axis_tdata  in  C*LW  lane i occupies bits [i*LW +: LW].
- s_axis_tvalid  in  C  per-lane valid.
- s_axis_tready  out  C  per-lane ready.
- s_axis_tlast  in  C  per-lane last.
- s_axis_tuser  in  C*UW  lane i occupies bits [i*UW +: UW].
- m_axis_tdata  out  C*LW  joined beat; lane order preserved.
- m_axis_tvalid  out  1  joined beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  lane-0 last.
- m_axis_tuser  out  UW  lane-0 user.
- err_pulse  out  1  one-cycle pulse per mismatched join.
- err_sticky  out  1  set on mismatch; cleared only by flush or reset.
- err_count  out  16  saturating mismatch count; cleared by flush or reset.
- lane_full  out  C  per-lane FIFO full flag.

Behaviour:
- Reset (rst_n low, async): all FIFOs empty; m_axis_tvalid=0; m_axis_tdata/tlast/tuser=0; err_pulse=0; err_sticky=0; err_count=0; lane_full=0; s_axis_tready=all-ones one cycle after deassertion (ready is derived from registered counts). Reset asserted mid-packet discards all buffered beats; no partial output.
- Lane FIFO i:
  - s_axis_tready[i] = !full_i, from the registered occupancy count.
  - Push when s_axis_tvalid[i] && s_axis_tready[i]. Each entry stores {tuser, tlast, tdata}.
  - A full FIFO does not accept a push even in a cycle it pops; ready rises the cycle after the pop.
  - Pointer wrap-around is modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Join condition J = all FIFOs non-empty && (!m_axis_tvalid || m_axis_tready).
  - On J, all C FIFOs pop in the same cycle and the output register loads.
  - No lane ever pops alone.
- Mismatch M (evaluated on FIFO heads at J): any lane tlast ≠ lane 0 tlast, or any lane tuser ≠ lane 0 tuser.
  - On J&&M: err_pulse=1 next cycle; err_sticky←1; err_count←min(count+1, 16'hFFFF).
  - DROP_ON_MISMATCH=0: beat emitted; m_axis_tlast/tuser taken from lane 0.
  - DROP_ON_MISMATCH=1: beat popped from all lanes but m_axis_tvalid not set by this join. A held output beat is still released normally by m_axis_tready.
- Output register:
  - m_axis_tvalid set on a non-dropped J.
  - Cleared on m_axis_tready when no new J.
  - Data, tlast and tuser are stable while valid && !ready (AXI rule; valid never drops without a handshake except on flush/reset).
- Latency: with all lanes empty and m_axis_tready=1, a beat pushed into the last lane at cycle t gives m_axis_tvalid=1 at cycle t+2.
- Throughput: 1 beat/cycle sustained when all lanes supply 1 beat/cycle and downstream is always ready (DEPTH≥2).
- flush (synchronous, takes priority over push/pop/join in the same cycle):
  - Next cycle: FIFOs empty, m_axis_tvalid=0, err_sticky=0, err_count=0, err_pulse=0.
  - s_axis_tready is held 0 during the flush cycle.
- Skew: lane i may lead the slowest lane by up to DEPTH beats. Beyond that, its ready deasserts (backpressure only; no loss).

Test Plan:
- C=3, LW=16, DEPTH=4: push beat {0x0011,0x0022,0x0033} on all lanes at cycle 0, ready=1 → m_axis_tvalid at cycle 2 with tdata=0x0033_0022_0011; err_count=0.
- Skew: lane 0 gets 4 beats (0x1..0x4), lanes 1-2 idle → lane_full[0]=1 and s_axis_tready[0]=0 on cycle 4, no output. Then lanes 1-2 supply 4 beats each → 4 joined beats in order 0x1..0x4; lane_full clears.
- Backpressure: m_axis_tready=0 for 10 cycles with a continuous stream → tdata held constant while valid. FIFOs fill and all ready bits go 0. Release ready → all beats out in order; no duplicates or loss.
- Mismatch, DROP_ON_MISMATCH=0: lane 2 tlast=1 while lanes 0/1 tlast=0 → beat emitted with m_axis_tlast=0, err_pulse one cycle, err_sticky=1, err_count=1.
- Mismatch, DROP_ON_MISMATCH=1: lane 1 tuser=3'b001 vs lane 0 tuser=3'b000 on beat 2 of 3 → only beats 1 and 3 emitted; err_count=1.
- flush with 2 beats buffered and m_axis_tvalid=1 → next cycle m_axis_tvalid=0, err_sticky=0, err_count=0. Async rst_n pulse mid-stream → all outputs at reset values immediately.
